// File: rtl/rs_issue_sched_pkg.sv
// Purpose : shared types, FU id constants and helpers for the RS issue scheduler.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package rs_issue_sched_pkg;

    localparam int RSW        = 16;
    localparam int RS_IDX_W   = $clog2(RSW);
    localparam int NFU        = 8;
    localparam int FU_ID_W    = 3;
    localparam int ISSUE_W    = 3;
    localparam int MULT_LAT   = 4;
    localparam int MULT_CNT_W = $clog2(MULT_LAT);

    // Fixed functional-unit ids.
    localparam int FU_ALU0  = 0;
    localparam int FU_ALU1  = 1;
    localparam int FU_ALU2  = 2;
    localparam int FU_LS0   = 3;
    localparam int FU_LS1   = 4;
    localparam int FU_MULT0 = 5;
    localparam int FU_MULT1 = 6;
    localparam int FU_BR0   = 7;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_LS   = 2'd1,
        FU_MULT = 2'd2,
        FU_BR   = 2'd3
    } fu_class_e;

    typedef struct packed {
        logic                valid;
        logic [RS_IDX_W-1:0] idx;
        logic [FU_ID_W-1:0]  fu;
    } issue_slot_t;

    // Which FU ids serve a class.
    function automatic logic [NFU-1:0] class_fu_mask(input fu_class_e cls);
        logic [NFU-1:0] m;
        m = '0;
        case (cls)
            FU_ALU:  m = 8'b0000_0111;
            FU_LS:   m = 8'b0001_1000;
            FU_MULT: m = 8'b0110_0000;
            default: m = 8'b1000_0000;
        endcase
        return m;
    endfunction

    // Lowest set FU id; 0 when the mask is empty (caller gates with a valid).
    function automatic logic [FU_ID_W-1:0] lowest_fu(input logic [NFU-1:0] m);
        logic [FU_ID_W-1:0] r;
        r = '0;
        for (int i = NFU - 1; i >= 0; i--) begin
            if (m[i]) r = FU_ID_W'(i);
        end
        return r;
    endfunction

    function automatic logic [RS_IDX_W-1:0] oh_to_idx(input logic [RSW-1:0] oh);
        logic [RS_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < RSW; i++) begin
            if (oh[i]) r = r | RS_IDX_W'(i);
        end
        return r;
    endfunction

    // Entries of rem whose class still has at least one available FU.
    function automatic logic [RSW-1:0] eligible(input logic [RSW-1:0]      rem,
                                                input logic [RSW-1:0][1:0] cls,
                                                input logic [NFU-1:0]      avail);
        logic [RSW-1:0] e;
        e = '0;
        for (int i = 0; i < RSW; i++) begin
            e[i] = rem[i] & (|(avail & class_fu_mask(fu_class_e'(cls[i]))));
        end
        return e;
    endfunction

endpackage

// File: rtl/rs_issue_sched_age_matrix.sv
// Purpose : 16x16 program-order age matrix with oldest-of-mask lookup (3 query ports).
// Latency : alloc updates visible the cycle after; queries are combinational.
// Backpressure: none; alloc and clear are always accepted.
//
// Ports: clock/reset (async active-low), clear (flush), alloc_en[slot] one-hot
// writes (slot 0 oldest), entry_valid (occupancy), qN_mask in -> qN_oldest one-hot out.
// age[i][j] = 1 means entry i is older than entry j.
module rs_age_matrix
    import rs_issue_sched_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [ISSUE_W-1:0][RSW-1:0] alloc_en,
    input  logic [RSW-1:0]             entry_valid,
    input  logic [RSW-1:0]             q0_mask,
    input  logic [RSW-1:0]             q1_mask,
    input  logic [RSW-1:0]             q2_mask,
    output logic [RSW-1:0]             q0_oldest,
    output logic [RSW-1:0]             q1_oldest,
    output logic [RSW-1:0]             q2_oldest
);

    logic [RSW-1:0][RSW-1:0] age;
    logic [RSW-1:0][RSW-1:0] age_nxt;
    logic [RSW-1:0][RSW-1:0] col;       // col[i][j] = age[j][i]: j older than i
    logic [RSW-1:0]          alloc_any;
    logic [RSW-1:0]          occ;
    logic [RSW-1:0]          earlier;

    assign alloc_any = alloc_en[0] | alloc_en[1] | alloc_en[2];
    // Entries being rewritten this cycle are not "other occupied" entries.
    assign occ       = entry_valid & ~alloc_any;

    always_comb begin
        age_nxt = age;
        earlier = '0;
        if (clear) begin
            age_nxt = '0;
        end else begin
            for (int s = 0; s < ISSUE_W; s++) begin
                for (int i = 0; i < RSW; i++) begin
                    if (alloc_en[s][i]) begin
                        age_nxt[i] = '0;
                        for (int j = 0; j < RSW; j++) begin
                            if (j != i && (occ[j] || earlier[j])) age_nxt[j][i] = 1'b1;
                        end
                    end
                end
                earlier = earlier | alloc_en[s];
            end
        end
    end

    always_comb begin
        col = '0;
        for (int i = 0; i < RSW; i++) begin
            for (int j = 0; j < RSW; j++) begin
                col[i][j] = age[j][i];
            end
        end
    end

    // Entry survives if no other masked entry is older; the final lowest-bit
    // isolation keeps the result one-hot even if two entries were never ordered.
    function automatic logic [RSW-1:0] pick_oldest(input logic [RSW-1:0]          q,
                                                   input logic [RSW-1:0][RSW-1:0] c);
        logic [RSW-1:0] f;
        f = '0;
        for (int i = 0; i < RSW; i++) begin
            f[i] = q[i] & ~(|(q & c[i]));
        end
        return f & (~f + RSW'(1));
    endfunction

    assign q0_oldest = pick_oldest(q0_mask, col);
    assign q1_oldest = pick_oldest(q1_mask, col);
    assign q2_oldest = pick_oldest(q2_mask, col);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) age <= '0;
        else        age <= age_nxt;
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Purpose : picks up to 3 oldest ready RS entries per cycle and binds each to a free FU.
// Latency : selection in cycle t is presented on registered outputs after edge t+1.
// Backpressure: FU availability (fu_ready=1, fu_busy=0) gates picks; unpicked entries wait.
//
// Ports: clock, reset (async active-low), alloc_EN[3] one-hot dispatch writes,
// entry_valid/entry_ready/entry_class per RS entry, fu_ready per FU, squash;
// out: issue_EN (1-cycle pulse per entry), issue_valid/issue_idx/issue_fu per slot, fu_busy.
// Optional: define RS_SCHED_PERF_EN for saturating perf_issued / perf_fu_stall counters.
module rs_issue_sched
    import rs_issue_sched_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ISSUE_W-1:0][RSW-1:0]       alloc_EN,
    input  logic [RSW-1:0]                    entry_valid,
    input  logic [RSW-1:0]                    entry_ready,
    input  logic [RSW-1:0][1:0]               entry_class,
    input  logic [NFU-1:0]                    fu_ready,
    input  logic                              squash,
    output logic [RSW-1:0]                    issue_EN,
    output logic [ISSUE_W-1:0]                issue_valid,
    output logic [ISSUE_W-1:0][RS_IDX_W-1:0]  issue_idx,
    output logic [ISSUE_W-1:0][FU_ID_W-1:0]   issue_fu,
    output logic [NFU-1:0]                    fu_busy
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_issued,
    output logic [31:0]                       perf_fu_stall
`endif
);

    logic [RSW-1:0]                      issue_en_q;   // doubles as the pending mask
    issue_slot_t [ISSUE_W-1:0]           slot_q;
    issue_slot_t [ISSUE_W-1:0]           slot_d;
    logic [1:0][MULT_CNT_W-1:0]          mult_cnt;

    logic [RSW-1:0] alloc_any;
    logic [RSW-1:0] cand;

    // Per-round chain: rem_k / avail_k in, oh_k picked, bound FU f_k.
    logic [RSW-1:0]      rem0, rem1, rem2;
    logic [NFU-1:0]      avail0, avail1, avail2, avail3;
    logic [RSW-1:0]      elig0, elig1, elig2;
    logic [RSW-1:0]      oh0, oh1, oh2;
    logic                v0, v1, v2;
    logic [RS_IDX_W-1:0] i0, i1, i2;
    logic [FU_ID_W-1:0]  f0, f1, f2;
    logic [NFU-1:0]      fu_claim;

    assign alloc_any = alloc_EN[0] | alloc_EN[1] | alloc_EN[2];
    assign cand      = entry_valid & entry_ready & ~issue_en_q & ~alloc_any;

    always_comb begin
        fu_busy           = '0;
        fu_busy[FU_MULT0] = |mult_cnt[0];
        fu_busy[FU_MULT1] = |mult_cnt[1];
    end

    // Round 0
    assign rem0   = cand;
    assign avail0 = fu_ready & ~fu_busy;
    assign elig0  = eligible(rem0, entry_class, avail0);
    assign v0     = |oh0;
    assign i0     = oh_to_idx(oh0);
    assign f0     = lowest_fu(avail0 & class_fu_mask(fu_class_e'(entry_class[i0])));
    assign avail1 = v0 ? (avail0 & ~(NFU'(1) << f0)) : avail0;
    assign rem1   = rem0 & ~oh0;

    // Round 1
    assign elig1  = eligible(rem1, entry_class, avail1);
    assign v1     = |oh1;
    assign i1     = oh_to_idx(oh1);
    assign f1     = lowest_fu(avail1 & class_fu_mask(fu_class_e'(entry_class[i1])));
    assign avail2 = v1 ? (avail1 & ~(NFU'(1) << f1)) : avail1;
    assign rem2   = rem1 & ~oh1;

    // Round 2
    assign elig2  = eligible(rem2, entry_class, avail2);
    assign v2     = |oh2;
    assign i2     = oh_to_idx(oh2);
    assign f2     = lowest_fu(avail2 & class_fu_mask(fu_class_e'(entry_class[i2])));
    assign avail3 = v2 ? (avail2 & ~(NFU'(1) << f2)) : avail2;

    assign fu_claim = avail0 & ~avail3;

    rs_age_matrix u_age (
        .clock       (clock),
        .reset       (reset),
        .clear       (squash),
        .alloc_en    (alloc_EN),
        .entry_valid (entry_valid),
        .q0_mask     (elig0),
        .q1_mask     (elig1),
        .q2_mask     (elig2),
        .q0_oldest   (oh0),
        .q1_oldest   (oh1),
        .q2_oldest   (oh2)
    );

    assign slot_d[0] = '{valid: v0, idx: v0 ? i0 : '0, fu: v0 ? f0 : '0};
    assign slot_d[1] = '{valid: v1, idx: v1 ? i1 : '0, fu: v1 ? f1 : '0};
    assign slot_d[2] = '{valid: v2, idx: v2 ? i2 : '0, fu: v2 ? f2 : '0};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_en_q <= '0;
            slot_q     <= '0;
            mult_cnt   <= '0;
        end else begin
            if (squash) begin
                issue_en_q <= '0;
                slot_q     <= '0;
            end else begin
                issue_en_q <= oh0 | oh1 | oh2;
                slot_q     <= slot_d;
            end
            // Counters keep running through squash: in-flight MULT ops still hold the unit.
            for (int m = 0; m < 2; m++) begin
                if (!squash && fu_claim[FU_MULT0 + m]) begin
                    mult_cnt[m] <= MULT_CNT_W'(MULT_LAT - 1);
                end else if (mult_cnt[m] != '0) begin
                    mult_cnt[m] <= mult_cnt[m] - MULT_CNT_W'(1);
                end
            end
        end
    end

    assign issue_EN = issue_en_q;

    always_comb begin
        issue_valid = '0;
        issue_idx   = '0;
        issue_fu    = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_valid[k] = slot_q[k].valid;
            issue_idx[k]   = slot_q[k].idx;
            issue_fu[k]    = slot_q[k].fu;
        end
    end

`ifdef RS_SCHED_PERF_EN
    logic [1:0]  n_issued;
    logic        fu_stall;
    logic [32:0] iss_sum;

    assign n_issued = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
    // A candidate whose class had no usable FU at the start of the cycle.
    assign fu_stall = |(cand & ~eligible(cand, entry_class, avail0));
    assign iss_sum  = {1'b0, perf_issued} + 33'(n_issued);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issued   <= '0;
            perf_fu_stall <= '0;
        end else if (!squash) begin
            perf_issued <= iss_sum[32] ? 32'hFFFF_FFFF : iss_sum[31:0];
            if (fu_stall && perf_fu_stall != 32'hFFFF_FFFF) begin
                perf_fu_stall <= perf_fu_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// Purpose : self-checking bench for rs_issue_sched against a sequence-number reference model.
// Latency : model predicts registered outputs one cycle after each driven cycle.
// Backpressure: FU readiness randomised; MULT occupancy tracked by grant cycle.
module tb_rs_issue_sched;

    localparam int N    = 16;
    localparam int MLAT = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [2:0][N-1:0]    alloc_EN;
    logic [N-1:0]         entry_valid;
    logic [N-1:0]         entry_ready;
    logic [N-1:0][1:0]    entry_class;
    logic [7:0]           fu_ready;
    logic                 squash;
    logic [N-1:0]         issue_EN;
    logic [2:0]           issue_valid;
    logic [2:0][3:0]      issue_idx;
    logic [2:0][2:0]      issue_fu;
    logic [7:0]           fu_busy;

    rs_issue_sched dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_EN    (alloc_EN),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_class (entry_class),
        .fu_ready    (fu_ready),
        .squash      (squash),
        .issue_EN    (issue_EN),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_fu    (issue_fu),
        .fu_busy     (fu_busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: RS contents, allocation order numbers, MULT grant cycles.
    bit          m_valid [N];
    int          m_seq   [N];
    int          m_cls   [N];
    logic [N-1:0] m_pending;
    int          seq_ctr;
    int          cyc;
    int          grant_cyc [8];

    logic [N-1:0]    e_en;
    logic [2:0]      e_vld;
    logic [2:0][3:0] e_idx;
    logic [2:0][2:0] e_fu;
    logic [7:0]      e_busy;

    function automatic int fu_lo(int c);
        case (c)
            0:       return 0;
            1:       return 3;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    function automatic int fu_hi(int c);
        case (c)
            0:       return 2;
            1:       return 4;
            2:       return 6;
            default: return 7;
        endcase
    endfunction

    // A MULT unit granted in cycle g is occupied in cycles g+1 .. g+MLAT-1.
    function automatic bit mult_busy(int f, int c);
        if (f != 5 && f != 6) return 1'b0;
        return (c - grant_cyc[f] >= 1) && (c - grant_cyc[f] <= MLAT - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_seq[i]   = 0;
            m_cls[i]   = 0;
        end
        for (int f = 0; f < 8; f++) grant_cyc[f] = -100;
        m_pending = '0;
        e_en = '0; e_vld = '0; e_idx = '0; e_fu = '0; e_busy = '0;
    endtask

    task automatic compare_outputs();
        check("issue_EN", 32'(issue_EN), 32'(e_en));
        check("issue_valid", 32'(issue_valid), 32'(e_vld));
        for (int k = 0; k < 3; k++) begin
            if (e_vld[k]) begin
                check($sformatf("issue_idx%0d", k), 32'(issue_idx[k]), 32'(e_idx[k]));
                check($sformatf("issue_fu%0d", k), 32'(issue_fu[k]), 32'(e_fu[k]));
            end
        end
        check("fu_busy", 32'(fu_busy), 32'(e_busy));
    endtask

    // One cycle: check the previous cycle's prediction, drive, predict the next.
    // a0..a2 = entry allocated in slot 0..2 (-1 none), c0..c2 their classes.
    task automatic step(input int a0, input int a1, input int a2,
                        input int c0, input int c1, input int c2,
                        input logic [N-1:0] rdy, input logic [7:0] fr, input bit sq);
        int           al [3];
        int           ac [3];
        bit           cand [N];
        logic [7:0]   avail;
        int           best;
        int           f;
        bit           ok;
        al[0] = a0; al[1] = a1; al[2] = a2;
        ac[0] = c0; ac[1] = c1; ac[2] = c2;
        @(negedge clock);
        compare_outputs();
        alloc_EN = '0;
        for (int s = 0; s < 3; s++) begin
            if (al[s] >= 0) begin
                alloc_EN[s][al[s]] = 1'b1;
                m_cls[al[s]] = ac[s];
            end
        end
        for (int i = 0; i < N; i++) begin
            entry_valid[i] = m_valid[i];
            entry_class[i] = 2'(m_cls[i]);
        end
        entry_ready = rdy;
        fu_ready    = fr;
        squash      = sq;

        for (int i = 0; i < N; i++) cand[i] = m_valid[i] && rdy[i] && !m_pending[i];
        for (int s = 0; s < 3; s++) if (al[s] >= 0) cand[al[s]] = 1'b0;
        for (int k = 0; k < 8; k++) avail[k] = fr[k] && !mult_busy(k, cyc);
        e_en = '0; e_vld = '0; e_idx = '0; e_fu = '0;
        for (int k = 0; k < 3; k++) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    ok = 1'b0;
                    for (int u = fu_lo(m_cls[i]); u <= fu_hi(m_cls[i]); u++) if (avail[u]) ok = 1'b1;
                    if (ok && (best < 0 || m_seq[i] < m_seq[best])) best = i;
                end
            end
            if (best >= 0) begin
                f = -1;
                for (int u = fu_hi(m_cls[best]); u >= fu_lo(m_cls[best]); u--) if (avail[u]) f = u;
                avail[f]   = 1'b0;
                cand[best] = 1'b0;
                if (!sq) begin
                    e_vld[k]   = 1'b1;
                    e_idx[k]   = 4'(best);
                    e_fu[k]    = 3'(f);
                    e_en[best] = 1'b1;
                    if (f == 5 || f == 6) grant_cyc[f] = cyc;
                end
            end
        end
        for (int k = 0; k < 8; k++) e_busy[k] = mult_busy(k, cyc + 1);

        for (int i = 0; i < N; i++) if (m_pending[i] || sq) m_valid[i] = 1'b0;
        if (!sq) begin
            for (int s = 0; s < 3; s++) begin
                if (al[s] >= 0) begin
                    m_valid[al[s]] = 1'b1;
                    m_seq[al[s]]   = seq_ctr;
                    seq_ctr++;
                end
            end
        end
        m_pending = e_en;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
    endtask

    initial begin
        int free_q [$];
        int pa [3];
        int pc [3];
        int n;
        int pos;

        seq_ctr = 0;
        cyc     = 0;
        model_reset();

        // Reset held with active inputs: outputs stay 0.
        reset       = 1'b0;
        alloc_EN    = '0;
        alloc_EN[0] = 16'h0001;
        entry_valid = '1;
        entry_ready = '1;
        entry_class = '0;
        fu_ready    = '1;
        squash      = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("rst_issue_EN", 32'(issue_EN), 32'h0);
            check("rst_issue_valid", 32'(issue_valid), 32'h0);
            check("rst_fu_busy", 32'(fu_busy), 32'h0);
        end
        alloc_EN    = '0;
        entry_valid = '0;
        reset       = 1'b1;
        idle(3);

        // Three ALU entries allocated 5,2,9 in slots 0,1,2.
        step(5, 2, 9, 0, 0, 0, '0, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("alu3_en", 32'(issue_EN), 32'h0224);
        check("alu3_idx", 32'(issue_idx), 32'({4'd9, 4'd2, 4'd5}));
        check("alu3_fu", 32'(issue_fu), 32'({3'd2, 3'd1, 3'd0}));
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("alu3_single_pulse", 32'(issue_EN), 32'h0);

        // Four LS entries 0..3: two LS units per cycle.
        step(0, 1, 2, 1, 1, 1, '0, 8'hFF, 1'b0);
        step(3, -1, -1, 1, 0, 0, '0, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("ls_first_en", 32'(issue_EN), 32'h0003);
        check("ls_first_valid", 32'(issue_valid), 32'b011);
        check("ls_first_fu0", 32'(issue_fu[0]), 32'd3);
        check("ls_first_fu1", 32'(issue_fu[1]), 32'd4);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("ls_second_en", 32'(issue_EN), 32'h000C);
        idle(2);

        // MULT occupancy: 7 -> FU5, 8 -> FU6, 10 waits for FU5.
        step(7, 8, 10, 2, 2, 2, '0, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("mult_fu0", 32'(issue_fu[0]), 32'd5);
        check("mult_fu1", 32'(issue_fu[1]), 32'd6);
        check("mult_busy", 32'(fu_busy), 32'h60);
        idle(3);
        check("mult_busy_end", 32'(fu_busy), 32'h00);
        idle(1);
        check("mult_third_en", 32'(issue_EN), 32'h0400);
        check("mult_third_fu", 32'(issue_fu[0]), 32'd5);
        idle(3);

        // Squash while ALU entries are ready; MULT countdown continues.
        step(1, 4, 6, 2, 0, 0, '0, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, 16'h0002, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b1);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("squash_en", 32'(issue_EN), 32'h0);
        check("squash_valid", 32'(issue_valid), 32'h0);
        check("squash_busy", 32'(fu_busy), 32'h20);
        idle(3);

        // Randomised traffic.
        for (int t = 0; t < 400; t++) begin
            bit sq;
            sq = ($urandom_range(0, 29) == 0);
            free_q.delete();
            for (int i = 0; i < N; i++) if (!m_valid[i]) free_q.push_back(i);
            n = sq ? 0 : $urandom_range(0, 3);
            for (int s = 0; s < 3; s++) begin
                pa[s] = -1;
                pc[s] = $urandom_range(0, 3);
                if (s < n && free_q.size() > 0) begin
                    pos   = $urandom_range(0, free_q.size() - 1);
                    pa[s] = free_q[pos];
                    free_q.delete(pos);
                end
            end
            step(pa[0], pa[1], pa[2], pc[0], pc[1], pc[2],
                 16'($urandom) | 16'($urandom), 8'($urandom) | 8'($urandom), sq);
        end

        // Asynchronous reset between edges drops outputs immediately.
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("areset_issue_EN", 32'(issue_EN), 32'h0);
        check("areset_issue_valid", 32'(issue_valid), 32'h0);
        check("areset_fu_busy", 32'(fu_busy), 32'h0);
        model_reset();
        @(negedge clock);
        alloc_EN    = '0;
        entry_valid = '0;
        squash      = 1'b0;
        reset       = 1'b1;
        idle(2);
        step(3, -1, -1, 0, 0, 0, '0, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        step(-1, -1, -1, 0, 0, 0, '1, 8'hFF, 1'b0);
        check("post_reset_en", 32'(issue_EN), 32'h0008);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
